// File: rtl/branch_resolve_scheduler_pkg.sv
// Shared types and sizing for the branch resolve scheduler.
package branch_resolve_scheduler_pkg;
    localparam int NUM_REQ        = 3;
    localparam int BM_W           = 4;
    localparam int ADDR_W         = 32;
    localparam int RECOVER_CYCLES = 2;
    localparam int CNT_W          = $clog2(BM_W + 1);
    localparam int REC_W          = $clog2(RECOVER_CYCLES + 1);

    typedef logic [BM_W-1:0]   b_mask_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // One completion report from an execute-stage branch unit
    typedef struct packed {
        logic    valid;
        b_mask_t tag;
        logic    mispred;
        b_mask_t dep_mask;
        addr_t   target;
    } br_report_t;

    typedef enum logic {IDLE = 1'b0, RECOVER = 1'b1} brs_state_e;

    // Slot table and FSM state, exported for assertion binds
    typedef struct packed {
        b_mask_t                      valid;
        b_mask_t                      mispred;
        logic [BM_W-1:0][BM_W-1:0]    dep_mask;
        brs_state_e                   state;
    } brs_debug_t;

    function automatic logic [CNT_W-1:0] popcount(b_mask_t m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < BM_W; i++) c += CNT_W'(m[i]);
        return c;
    endfunction
endpackage

// File: rtl/branch_resolve_scheduler_if.sv
// Completion-report and resolution bus between branch units, scheduler and branch stack.
interface branch_resolve_scheduler_if;
    import branch_resolve_scheduler_pkg::*;

    br_report_t [NUM_REQ-1:0] req;
    b_mask_t                  b_mm_resolve;
    logic                     b_mm_mispred;
    addr_t                    resolve_target;
    logic                     stall_dispatch;
    logic [CNT_W-1:0]         pending_cnt;
    logic                     dup_error;

    modport master (
        output req,
        input  b_mm_resolve, b_mm_mispred, resolve_target,
        input  stall_dispatch, pending_cnt, dup_error
    );

    modport slave (
        input  req,
        output b_mm_resolve, b_mm_mispred, resolve_target,
        output stall_dispatch, pending_cnt, dup_error
    );
endinterface

// File: rtl/branch_resolve_scheduler_oldest_sel.sv
// Picks the oldest pending mispredicted slot: one whose dep_mask names no other
// pending mispredicted slot. Lowest index wins if several qualify.
module branch_resolve_scheduler_oldest_sel
    import branch_resolve_scheduler_pkg::*;
(
    input  b_mask_t                   valid,
    input  b_mask_t                   mispred,
    input  logic [BM_W-1:0][BM_W-1:0] dep_mask,
    output b_mask_t                   sel,
    output logic                      found
);
    b_mask_t cand;
    b_mask_t oldest;

    assign cand = valid & mispred;

    for (genvar i = 0; i < BM_W; i++) begin : g_oldest
        assign oldest[i] = cand[i] && ((dep_mask[i] & cand & ~(b_mask_t'(1) << i)) == '0);
    end

    // Lowest-index priority pick among the oldest candidates
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < BM_W; i++) begin
            if (oldest[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/branch_resolve_scheduler.sv
// Buffers branch completion reports per tag and issues resolutions to the
// branch stack: one mispredict at a time, or all correct predictions at once.
// A mispredict squashes dependent reports and stalls dispatch while recovering.
module branch_resolve_scheduler
    import branch_resolve_scheduler_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    branch_resolve_scheduler_if.slave   bus,
    output brs_debug_t                  debug
);
    b_mask_t                   valid_q, valid_d;
    b_mask_t                   mispred_q, mispred_d;
    logic [BM_W-1:0][BM_W-1:0] dep_q, dep_d;
    addr_t [BM_W-1:0]          target_q, target_d;
    logic                      dup_q, dup_set;
    brs_state_e                state_q, state_d;
    logic [REC_W-1:0]          cnt_q, cnt_d;

    b_mask_t                   mis_sel;
    logic                      mis_found;
    b_mask_t                   resolve;
    logic                      mis_issue;
    addr_t                     tgt_mux;
    b_mask_t                   kill;
    logic [NUM_REQ-1:0]        acc;
    b_mask_t                   hit;

    branch_resolve_scheduler_oldest_sel u_sel (
        .valid    (valid_q),
        .mispred  (mispred_q),
        .dep_mask (dep_q),
        .sel      (mis_sel),
        .found    (mis_found)
    );

    // Issue selection; nothing issues while recovering
    always_comb begin
        resolve   = '0;
        mis_issue = 1'b0;
        tgt_mux   = '0;
        if (state_q == IDLE) begin
            if (mis_found) begin
                resolve   = mis_sel;
                mis_issue = 1'b1;
                for (int i = 0; i < BM_W; i++)
                    if (mis_sel[i]) tgt_mux = target_q[i];
            end else begin
                resolve = valid_q;
            end
        end
    end

    assign kill = mis_issue ? resolve : '0;

    // Reports dependent on the branch being squashed never enter the table
    always_comb begin
        for (int p = 0; p < NUM_REQ; p++)
            acc[p] = bus.req[p].valid && ((bus.req[p].dep_mask & kill) == '0);
    end

    // Slot table update: retire issued, squash dependents, then accept reports
    always_comb begin
        valid_d   = valid_q & ~resolve;
        mispred_d = mispred_q;
        target_d  = target_q;
        dep_d     = dep_q;
        dup_set   = 1'b0;
        hit       = '0;
        for (int i = 0; i < BM_W; i++) begin
            if ((dep_q[i] & kill) != '0) valid_d[i] = 1'b0;
            dep_d[i] = dep_q[i] & ~resolve;
            for (int p = 0; p < NUM_REQ; p++) begin
                if (acc[p] && bus.req[p].tag[i]) begin
                    // Lower port already claimed the slot, or slot still held an entry
                    if (hit[i] || valid_q[i]) dup_set = 1'b1;
                    if (!hit[i]) begin
                        valid_d[i]   = 1'b1;
                        mispred_d[i] = bus.req[p].mispred;
                        dep_d[i]     = bus.req[p].dep_mask & ~resolve;
                        target_d[i]  = bus.req[p].target;
                    end
                    hit[i] = 1'b1;
                end
            end
        end
    end

    // Slot registers and sticky duplicate flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            mispred_q <= '0;
            dep_q     <= '0;
            target_q  <= '0;
            dup_q     <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            mispred_q <= mispred_d;
            dep_q     <= dep_d;
            target_q  <= target_d;
            dup_q     <= dup_q | dup_set;
        end
    end

    // Recovery FSM state and window counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Recovery FSM next state: a mispredict issue opens a fixed stall window
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mis_issue) begin
                    state_d = RECOVER;
                    cnt_d   = REC_W'(RECOVER_CYCLES);
                end
            end
            RECOVER: begin
                if (cnt_q == REC_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - REC_W'(1);
                end
            end
        endcase
    end

    assign bus.b_mm_resolve   = resolve;
    assign bus.b_mm_mispred   = mis_issue;
    assign bus.resolve_target = tgt_mux;
    assign bus.stall_dispatch = (state_q == RECOVER) || mis_issue;
    assign bus.pending_cnt    = popcount(valid_q);
    assign bus.dup_error      = dup_q;

    assign debug.valid    = valid_q;
    assign debug.mispred  = mispred_q;
    assign debug.dep_mask = dep_q;
    assign debug.state    = state_q;
endmodule
